div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the execute stage. It serves DIV/DIVU, which are among the instructions the main decoder flags for a HI/LO write.
- Accepts dividend/divisor from EX and holds the pipeline stall while it iterates.
- Returns {remainder, quotient} for the HI/LO write port: remainder goes to HI, quotient goes to LO.
- One divide in flight at a time; a flush from the pipeline annuls it.

Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset, sampled on rising edge of clk.
- start  in  1  EX holds a DIV/DIVU; held high until ready is observed.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- opdata1  in  WIDTH  dividend; sampled with start.
- opdata2  in  WIDTH  divisor; sampled with start.
- annul  in  1  pipeline flush; aborts current operation.
- stall  out  1  request to hold IF..EX.
- ready  out  1  result valid.
- result  out  2*WIDTH  {remainder, quotient}, i.e. {HI, LO}.

Behaviour:
- Reset (resetn=0 at edge): state=IDLE, counter=0, result=0, ready=0. stall is combinational and also 0 during reset.
- States: IDLE, DIVZERO, BUSY, DONE.
- IDLE:
  - start=1 and annul=0 with opdata2==0: go to DIVZERO.
  - start=1 and annul=0 otherwise: go to BUSY.
  - On capture:
    - Latch abs(opdata1) and abs(opdata2) when signed_div=1, else the raw values.
    - Latch sign_q = opdata1[MSB]^opdata2[MSB] and sign_r = opdata1[MSB], both gated by signed_div.
    - Clear the partial remainder; counter=0.
- BUSY: one iteration per cycle, WIDTH cycles in total.
  - Each iteration: shift {rem, quo} left by 1; trial = rem - divisor on WIDTH+1 bits.
  - Trial non-negative: rem = trial and quotient LSB = 1. Otherwise quotient LSB = 0.
  - counter increments each iteration; when counter == WIDTH-1, go to DONE.
- DIVZERO: one cycle, then DONE. Defined result: HI = opdata1 as captured (raw), LO = all ones.
- DONE:
  - ready=1.
  - Signed correction is applied when the result is registered on entry to DONE: quotient negated if sign_q, remainder negated if sign_r.
  - Stays in DONE while start=1; goes to IDLE when start=0. The pipeline drops start once it advances.
- Latency: start sampled at edge 0 → ready high from edge WIDTH+1 (33 cycles for a normal divide); divide-by-zero → ready after 2 cycles.
- stall = (state==IDLE & start & ~annul) | (state==DIVZERO) | (state==BUSY). stall is 0 in DONE, so EX advances in the same cycle ready is seen.
- annul:
  - In DIVZERO/BUSY/DONE: go to IDLE next edge, ready=0, result unchanged, no ready pulse.
  - In IDLE: a start in the same cycle is ignored.
- Signed edge case: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
- result holds its last value in IDLE. Consumers qualify it with ready only.
- Back-to-back divides: start must deassert for at least one cycle; DONE→IDLE→BUSY.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in IDLE, if the captured |dividend| < |divisor| (unsigned compare of magnitudes) and the divisor is non-zero, go directly to DONE with quotient 0 and remainder = dividend (raw, sign preserved). ready rises after 1 cycle.
- Undefined: every non-zero-divisor operation takes the full WIDTH iterations. Results are bit-identical in both builds; only latency differs.

Decomposition:
- Shared package/defines: DIV_STATE_IDLE/DIVZERO/BUSY/DONE 2-bit encodings, DIV_WIDTH, and the existing EXE_DIV/EXE_DIVU funct codes (already in defines.vh).
- One natural sub-module: div_abs_sign. It is combinational and handles operand magnitude plus final sign correction; it is instantiated twice, pre- and post-iteration.
- Iteration datapath and FSM stay in div_unit.

Test Plan:
- DIVU 100 / 7 → ready at cycle 33; result {HI,LO} = {0x00000002, 0x0000000E}; stall high cycles 0..32, low at 33.
- DIV -7 / 2 (0xFFFFFFF9 / 0x00000002) → LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1).
- DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0; DIVU of the same operands → LO = 0, HI = 0x80000000.
- DIVU 5 / 0 → DIVZERO path; ready at cycle 2; HI = 5, LO = 0xFFFFFFFF.
- Start DIV 1000/3, assert annul at cycle 10 → IDLE at cycle 11, ready never rises, stall low. A fresh DIVU 9/3 then gives LO = 3, HI = 0.
- Hold start in DONE for 3 cycles → ready stays 1 and no re-launch. Reset mid-BUSY → all outputs 0 next edge. With DIV_EARLY_OUT_EN, DIVU 3/10 → ready at cycle 1, LO = 0, HI = 3.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared constants for the iterative divider: FSM encodings, default width and
// the execute-stage funct codes that route DIV/DIVU into this unit.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] DIV_STATE_IDLE    = 2'b00;
  localparam logic [1:0] DIV_STATE_DIVZERO = 2'b01;
  localparam logic [1:0] DIV_STATE_BUSY    = 2'b10;
  localparam logic [1:0] DIV_STATE_DONE    = 2'b11;

  localparam logic [5:0] EXE_DIV  = 6'b011010;
  localparam logic [5:0] EXE_DIVU = 6'b011011;

endpackage

// File: rtl/div_abs_sign.sv
// Conditional two's-complement negation of an operand pair. Used once to take
// operand magnitudes and once to restore the sign of quotient and remainder.
module div_abs_sign
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             neg_a,
  input  logic             neg_b,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out
);

  assign a_out = neg_a ? (-a) : a;
  assign b_out = neg_b ? (-b) : b;

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient} = {HI, LO}.
// Build option DIV_EARLY_OUT_EN skips iteration when |dividend| < |divisor|.
//
// state   | meaning
// IDLE    | waiting for start; captures operands
// DIVZERO | divisor was zero; loads the defined result
// BUSY    | one quotient bit per cycle, WIDTH cycles
// DONE    | result valid, ready high until start drops
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic               stall,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] rem, quo, divisor, dividend_raw;
  logic             sign_q, sign_r;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] rem_next, quo_next, rem_fix, quo_fix;
  logic [WIDTH:0]   shifted;
  logic             trial_ok;
  logic             launch;

  assign launch = start & ~annul;

  div_abs_sign #(.WIDTH(WIDTH)) u_pre (
    .a     (opdata1),
    .b     (opdata2),
    .neg_a (signed_div & opdata1[WIDTH-1]),
    .neg_b (signed_div & opdata2[WIDTH-1]),
    .a_out (abs_a),
    .b_out (abs_b)
  );

  // Shifted remainder is WIDTH+1 bits wide so the trial compare never overflows.
  assign shifted  = {rem, quo[WIDTH-1]};
  assign trial_ok = (shifted >= {1'b0, divisor});
  assign rem_next = trial_ok ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], trial_ok};

  div_abs_sign #(.WIDTH(WIDTH)) u_post (
    .a     (quo_next),
    .b     (rem_next),
    .neg_a (sign_q),
    .neg_b (sign_r),
    .a_out (quo_fix),
    .b_out (rem_fix)
  );

  assign stall = resetn & (((state == DIV_STATE_IDLE) & launch) |
                           (state == DIV_STATE_DIVZERO) |
                           (state == DIV_STATE_BUSY));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= DIV_STATE_IDLE;
      counter      <= '0;
      result       <= '0;
      ready        <= 1'b0;
      rem          <= '0;
      quo          <= '0;
      divisor      <= '0;
      dividend_raw <= '0;
      sign_q       <= 1'b0;
      sign_r       <= 1'b0;
    end else begin
      case (state)
        DIV_STATE_IDLE: begin
          if (launch) begin
            rem          <= '0;
            quo          <= abs_a;
            divisor      <= abs_b;
            dividend_raw <= opdata1;
            sign_q       <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            sign_r       <= signed_div & opdata1[WIDTH-1];
            counter      <= '0;
            if (opdata2 == '0) begin
              state <= DIV_STATE_DIVZERO;
`ifdef DIV_EARLY_OUT_EN
            end else if (abs_a < abs_b) begin
              // Quotient is zero, so the remainder is the dividend with its own sign.
              state  <= DIV_STATE_DONE;
              result <= {opdata1, {WIDTH{1'b0}}};
              ready  <= 1'b1;
`endif
            end else begin
              state <= DIV_STATE_BUSY;
            end
          end
        end
        DIV_STATE_DIVZERO: begin
          if (annul) begin
            state <= DIV_STATE_IDLE;
            ready <= 1'b0;
          end else begin
            state  <= DIV_STATE_DONE;
            result <= {dividend_raw, {WIDTH{1'b1}}};
            ready  <= 1'b1;
          end
        end
        DIV_STATE_BUSY: begin
          if (annul) begin
            state <= DIV_STATE_IDLE;
            ready <= 1'b0;
          end else begin
            rem     <= rem_next;
            quo     <= quo_next;
            counter <= counter + CW'(1);
            if (counter == LAST) begin
              state  <= DIV_STATE_DONE;
              result <= {rem_fix, quo_fix};
              ready  <= 1'b1;
            end
          end
        end
        default: begin
          if (annul || !start) begin
            state <= DIV_STATE_IDLE;
            ready <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, stall, results, annul and reset cases.
// Expected latency follows the DIV_EARLY_OUT_EN build option.
module tb_div_unit;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           resetn, start, signed_div, annul;
  logic [W-1:0]   opdata1, opdata2;
  logic           stall, ready;
  logic [2*W-1:0] result;

  int passed = 0;
  int total  = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .stall      (stall),
    .ready      (ready),
    .result     (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int exp_lat(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ma, mb;
    ma = (sgn && a[W-1]) ? -a : a;
    mb = (sgn && b[W-1]) ? -b : b;
    if (b == '0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    return (ma == mb) ? 33 : 33;
  endfunction

  // Launches a divide and leaves start high with the unit in DONE.
  task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [63:0] exp_res);
    int cyc;
    logic stall_ok;
    @(negedge clk);
    start = 1'b1; signed_div = sgn; opdata1 = a; opdata2 = b; annul = 1'b0;
    #1 check({tag, "_stall_c0"}, stall, 1'b1);
    cyc = 0;
    stall_ok = 1'b1;
    while (cyc < 100 && ready !== 1'b1) begin
      @(posedge clk); #1;
      cyc++;
      if (ready !== 1'b1 && stall !== 1'b1) stall_ok = 1'b0;
    end
    check({tag, "_latency"}, cyc, exp_lat(sgn, a, b));
    check({tag, "_stall_busy"}, stall_ok, 1'b1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_stall_done"}, stall, 1'b0);
  endtask

  task automatic finish_div(input string tag);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ready_drop"}, ready, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; start = 1'b1; signed_div = 1'b0; annul = 1'b0;
    opdata1 = 32'd100; opdata2 = 32'd7;
    @(posedge clk); #1;
    check("rst_ready", ready, 1'b0);
    check("rst_result", result, 64'h0);
    check("rst_stall", stall, 1'b0);
    @(negedge clk);
    start = 1'b0; resetn = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", ready, 1'b0);

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'h00000002, 32'h0000000E});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_ready", ready, 1'b1);
      check("hold_stall", stall, 1'b0);
    end
    check("hold_result", result, {32'h00000002, 32'h0000000E});
    finish_div("divu_100_7");

    run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'h00000002, {32'hFFFFFFFF, 32'hFFFFFFFD});
    finish_div("div_m7_2");

    run_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000});
    finish_div("div_min_m1");

    run_div("divu_min_m1", 1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h00000000});
    finish_div("divu_min_m1");

    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, {32'h00000005, 32'hFFFFFFFF});
    finish_div("divu_5_0");

    // Annul mid-BUSY: drive annul during cycle 10, unit idle in cycle 11.
    @(negedge clk);
    start = 1'b1; signed_div = 1'b1; opdata1 = 32'd1000; opdata2 = 32'd3;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("annul_c10_stall", stall, 1'b1);
    annul = 1'b1;
    @(posedge clk); #1;
    check("annul_c11_ready", ready, 1'b0);
    check("annul_c11_stall", stall, 1'b0);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("annul_no_ready", ready, 1'b0);
    check("annul_result_kept", result, {32'h00000005, 32'hFFFFFFFF});
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'h00000000, 32'h00000003});
    finish_div("divu_9_3");

    // Annul in IDLE suppresses the launch.
    @(negedge clk);
    start = 1'b1; annul = 1'b1; signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd5;
    #1 check("idle_annul_stall", stall, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_annul_ready", ready, 1'b0);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    @(posedge clk); #1;
    check("idle_annul_stall_after", stall, 1'b0);

    run_div("divu_3_10", 1'b0, 32'd3, 32'd10, {32'h00000003, 32'h00000000});
    finish_div("divu_3_10");

    // Synchronous reset while BUSY.
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    repeat (5) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1 check("rstbusy_stall_comb", stall, 1'b0);
    @(posedge clk); #1;
    check("rstbusy_ready", ready, 1'b0);
    check("rstbusy_result", result, 64'h0);
    check("rstbusy_stall", stall, 1'b0);
    @(negedge clk);
    start = 1'b0; resetn = 1'b1;
    @(posedge clk); #1;
    check("rstbusy_idle_stall", stall, 1'b0);
    check("rstbusy_idle_ready", ready, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
